matrix_execute_unit: RTL and testbench

- Execute stage directly downstream of the matrix data memory.
- Consumes the two WIDTH x WIDTH x 32-bit operand matrices from the memory read ports. The B operand may be the broadcast constant matrix.
- Performs one matrix operation per command, over one or more cycles.
- Returns the result with a one-cycle write strobe and a destination index. These connect directly to the memory's write_data, write and write_enable inputs.

---
 rtl/matrix_execute_unit_pkg.sv | 26 ++
 rtl/matrix_row_mac.sv | 22 ++
 rtl/matrix_execute_unit.sv | 135 +++++++++++++
 tb/tb_matrix_execute_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_execute_unit_pkg.sv
// Shared constants for the matrix execute stage: geometry, opcodes, FSM states.
package matrix_execute_unit_pkg;

  localparam int WIDTH_BIT = 2;
  localparam int INDEX_BIT = 4;

  localparam logic [2:0] OP_ADD       = 3'b000;
  localparam logic [2:0] OP_SUB       = 3'b001;
  localparam logic [2:0] OP_EMUL      = 3'b010;
  localparam logic [2:0] OP_MATMUL    = 3'b011;
  localparam logic [2:0] OP_TRANSPOSE = 3'b100;
  localparam logic [2:0] OP_MOV       = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_MM   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Opcodes 110 and 111 have no operation assigned.
  function automatic logic op_reserved(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/matrix_row_mac.sv
// One output row of a matrix product: WIDTH dot products of a row of A with the columns of B.
module matrix_row_mac
  import matrix_execute_unit_pkg::*;
#(
  parameter int WIDTH = 2**WIDTH_BIT
) (
  input  logic [0:WIDTH-1][31:0]            a_row,
  input  logic [0:WIDTH-1][0:WIDTH-1][31:0] b,
  output logic [0:WIDTH-1][31:0]            row_out
);

  // Each product and the running sum wrap at 32 bits.
  always_comb begin
    row_out = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        row_out[j] = row_out[j] + a_row[k] * b[k][j];
      end
    end
  end

endmodule

// File: rtl/matrix_execute_unit.sv
// Matrix execute stage: latches two operand matrices, performs one operation,
// and presents a registered result with a one-cycle write strobe.
module matrix_execute_unit
  import matrix_execute_unit_pkg::*;
#(
  parameter int WIDTH = 2**WIDTH_BIT,
  parameter int IDX   = INDEX_BIT
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              start,
  input  logic [2:0]                        opcode,
  input  logic [IDX-1:0]                    dest,
  input  logic [0:WIDTH-1][0:WIDTH-1][31:0] operand_a,
  input  logic [0:WIDTH-1][0:WIDTH-1][31:0] operand_b,
  output logic                              busy,
  output logic                              done,
  output logic                              illegal,
  output logic                              write_enable,
  output logic [IDX-1:0]                    write_index,
  output logic [0:WIDTH-1][0:WIDTH-1][31:0] result
);

  localparam int RW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state, state_nxt;

  logic [0:WIDTH-1][0:WIDTH-1][31:0] a_q, b_q, calc_result;
  logic [0:WIDTH-1][31:0]            mac_row;
  logic [2:0]                        op_q;
  logic [IDX-1:0]                    dest_q;
  logic [RW-1:0]                     row;
  logic                              last_row;

  assign last_row = (row == RW'(WIDTH - 1));

  matrix_row_mac #(.WIDTH(WIDTH)) u_row_mac (
    .a_row   (a_q[row]),
    .b       (b_q),
    .row_out (mac_row)
  );

  // Single-cycle elementwise / permutation results; reserved opcodes yield zero.
  always_comb begin
    calc_result = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        case (op_q)
          OP_ADD:       calc_result[i][j] = a_q[i][j] + b_q[i][j];
          OP_SUB:       calc_result[i][j] = a_q[i][j] - b_q[i][j];
          OP_EMUL:      calc_result[i][j] = a_q[i][j] * b_q[i][j];
          OP_TRANSPOSE: calc_result[i][j] = a_q[j][i];
          OP_MOV:       calc_result[i][j] = b_q[i][j];
          default:      calc_result[i][j] = '0;
        endcase
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;
    write_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (opcode == OP_MATMUL) ? ST_MM : ST_CALC;
      end
      ST_CALC: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_MM: begin
        busy = 1'b1;
        if (last_row) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        illegal      = op_reserved(op_q);
        write_enable = ~op_reserved(op_q);
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, row sequencing and result registers.
  // write_index is loaded on the edge entering DONE so it tracks result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      dest_q      <= '0;
      row         <= '0;
      result      <= '0;
      write_index <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q    <= operand_a;
            b_q    <= operand_b;
            op_q   <= opcode;
            dest_q <= dest;
            row    <= '0;
          end
        end
        ST_CALC: begin
          result      <= calc_result;
          write_index <= dest_q;
        end
        ST_MM: begin
          result[row] <= mac_row;
          if (last_row) begin
            row         <= '0;
            write_index <= dest_q;
          end else begin
            row <= row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_execute_unit.sv
// Self-checking bench for matrix_execute_unit (WIDTH=4, IDX=4).
module tb_matrix_execute_unit;

  localparam int W = 4;
  typedef logic [0:W-1][0:W-1][31:0] mat_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic [2:0] opcode = '0;
  logic [3:0] dest = '0;
  mat_t       operand_a = '0;
  mat_t       operand_b = '0;
  logic       busy, done, illegal, write_enable;
  logic [3:0] write_index;
  mat_t       result;

  matrix_execute_unit #(.WIDTH(W), .IDX(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .opcode       (opcode),
    .dest         (dest),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal),
    .write_enable (write_enable),
    .write_index  (write_index),
    .result       (result)
  );

  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // Reference model: what the operation means, computed directly.
  function automatic mat_t model(input logic [2:0] op, input mat_t a, input mat_t b);
    mat_t r;
    logic [31:0] s;
    r = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++) begin
        case (op)
          3'b000: r[i][j] = a[i][j] + b[i][j];
          3'b001: r[i][j] = a[i][j] - b[i][j];
          3'b010: r[i][j] = a[i][j] * b[i][j];
          3'b011: begin
            s = 0;
            for (int k = 0; k < W; k++) s = s + a[i][k] * b[k][j];
            r[i][j] = s;
          end
          3'b100: r[i][j] = a[j][i];
          3'b101: r[i][j] = b[i][j];
          default: r[i][j] = 0;
        endcase
      end
    return r;
  endfunction

  function automatic mat_t fill(input logic [31:0] v);
    mat_t m;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic mat_t ramp();
    mat_t m;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++) m[i][j] = 32'(4 * i + j);
    return m;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    m = '0;
    for (int i = 0; i < W; i++) m[i][i] = 32'd1;
    return m;
  endfunction

  function automatic mat_t garbage();
    mat_t m;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++) m[i][j] = $urandom;
    return m;
  endfunction

  // Expected command timeline: accept edge and the edge after which done is high.
  logic       m_active = 1'b0;
  logic [2:0] m_op = '0;
  logic [3:0] m_dest = '0;
  mat_t       m_a = '0, m_b = '0;
  int         m_acc = 0, m_done = 0;
  mat_t       exp_result = '0;
  logic [3:0] exp_widx = '0;

  // Per-cycle compare of all outputs against the timeline model.
  always @(negedge CLK) begin
    logic e_busy, e_done, e_res;
    if (!RST) begin
      e_busy = m_active && cyc >= m_acc && cyc < m_done;
      e_done = m_active && cyc == m_done;
      e_res  = (m_op[2] & m_op[1]);
      if (e_done) begin
        exp_result = model(m_op, m_a, m_b);
        exp_widx   = m_dest;
      end
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("illegal", illegal, e_done && e_res);
      check("write_enable", write_enable, e_done && !e_res);
      if (!e_busy) begin
        check("result", result, exp_result);
        check("write_index", write_index, exp_widx);
      end
    end
  end

  task automatic run_cmd(input logic [2:0] op, input logic [3:0] d, input mat_t a, input mat_t b);
    @(negedge CLK); #2;
    start = 1'b1; opcode = op; dest = d; operand_a = a; operand_b = b;
    m_op = op; m_dest = d; m_a = a; m_b = b;
    m_acc = cyc + 1;
    m_done = m_acc + ((op == 3'b011) ? W : 1);
    m_active = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; opcode = 3'($urandom); dest = 4'($urandom);
    operand_a = garbage(); operand_b = garbage();
  endtask

  initial begin
    mat_t t;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_we", write_enable, 1'b0);
    check("reset_result", result, '0);
    check("reset_widx", write_index, 4'd0);
    @(negedge CLK); @(negedge CLK); #2 RST = 1'b0;

    // Hand-computed pins on the model itself.
    t = model(3'b000, fill(5), fill(3));            check("model_add", t[2][1], 32'd8);
    t = model(3'b001, fill(0), fill(1));            check("model_sub", t[0][3], 32'hFFFF_FFFF);
    t = model(3'b010, fill(32'h10000), fill(32'h10000)); check("model_emul", t[1][1], 32'd0);
    t = model(3'b011, ident(), ramp());             check("model_mm_id", t[2][3], 32'd11);
    t = model(3'b011, fill(1), fill(2));            check("model_mm_bc", t[3][0], 32'd8);
    t = model(3'b100, ramp(), fill(0));             check("model_tr", t[1][2], 32'd9);

    run_cmd(3'b000, 4'd2, fill(5), fill(3));
    repeat (5) @(negedge CLK);
    check("add_lit", result, fill(8));
    check("add_widx", write_index, 4'd2);

    run_cmd(3'b001, 4'd3, fill(0), fill(1));
    repeat (5) @(negedge CLK);
    check("sub_lit", result, fill(32'hFFFF_FFFF));

    run_cmd(3'b010, 4'd4, fill(32'h10000), fill(32'h10000));
    repeat (5) @(negedge CLK);
    check("emul_lit", result, fill(0));

    run_cmd(3'b011, 4'd5, ident(), ramp());
    repeat (5) @(negedge CLK);
    check("mm_id_lit", result, ramp());

    run_cmd(3'b011, 4'd6, fill(1), fill(2));
    repeat (5) @(negedge CLK);
    check("mm_bc_lit", result, fill(8));

    run_cmd(3'b101, 4'd7, fill(9), ramp());
    repeat (5) @(negedge CLK);
    check("mov_lit", result, ramp());

    // Transpose with a stray start while busy: must be ignored.
    run_cmd(3'b100, 4'd8, ramp(), fill(0));
    #2 start = 1'b1; opcode = 3'b000;
    @(posedge CLK); #1 start = 1'b0;
    repeat (5) @(negedge CLK);
    t = result;
    check("tr_lit", t[1][2], 32'd9);
    check("tr_lit2", t[3][0], 32'd3);

    run_cmd(3'b110, 4'd9, fill(7), fill(7));
    repeat (5) @(negedge CLK);
    check("illegal_result", result, fill(0));

    // Reset during MATMUL row 2.
    run_cmd(3'b011, 4'd10, ramp(), ramp());
    repeat (3) @(negedge CLK);
    #1 RST = 1'b1;
    m_active = 1'b0; exp_result = '0; exp_widx = '0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_we", write_enable, 1'b0);
    check("rst_result", result, '0);
    check("rst_widx", write_index, 4'd0);
    @(negedge CLK); #2 RST = 1'b0;
    repeat (8) @(negedge CLK);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
